packet_receiver: RTL and testbench
==================================

PACKET_RECEIVER -- requirements
Module: packet_receiver

Interface
REQ-001 SHALL have parameter PACKET_SIZE, default 256, meaning total packet bits (header 64 + payload + footer 64), multiple of 4.
REQ-002 SHALL have parameter TERMINATOR, default 8'h0D, meaning the end-of-packet character.
REQ-003 SHALL have input clk, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have input reset, 1 bit: asynchronous, active-high.
REQ-005 SHALL have input RXREG, 8 bits: received character.
REQ-006 SHALL have input RXIF, 1 bit: one-cycle strobe qualifying RXREG.
REQ-007 SHALL have output packet_data, PACKET_SIZE bits: last complete packet, MSB = first nibble received.
REQ-008 SHALL have output packet_valid, 1 bit: one-cycle pulse when packet_data updates.
REQ-009 SHALL have output packet_error, 1 bit: one-cycle pulse on framing error.
REQ-010 SHALL have output busy, 1 bit: high while a packet is in progress.
REQ-011 SHALL have outputs timestamp[63:0], tick[15:0], flags[3:0], lag_cross[7:0], lag_auto[7:0], delay_size[11:0], num_inputs[7:0] and resolution[7:0], decoded from packet_data.

Function
REQ-012 SHALL decode ASCII '0'-'9', 'A'-'F' and 'a'-'f' to nibbles; every other character is non-hex.
REQ-013 SHALL implement the states IDLE, RECV, WAIT_EOL.
REQ-014 In IDLE, a hex RXIF SHALL store its nibble at shift[3:0], set nibble count to 1 and go to RECV; TERMINATOR, 8'h0A and other non-hex characters SHALL be ignored.
REQ-015 In RECV, each hex RXIF SHALL shift left 4 and append the nibble; when the count reaches PACKET_SIZE/4, the next state SHALL be WAIT_EOL.
REQ-016 In RECV, a non-hex RXIF (including TERMINATOR) SHALL pulse packet_error, discard the shift register and return to IDLE.
REQ-017 In WAIT_EOL, RXIF with TERMINATOR SHALL copy the shift register to packet_data, pulse packet_valid the following cycle and return to IDLE.
REQ-018 In WAIT_EOL, any other RXIF (overrun) SHALL pulse packet_error and return to IDLE.
REQ-019 Latency SHALL be: packet_valid asserted exactly 1 clk after the cycle in which TERMINATOR was sampled.
REQ-020 packet_data and all decoded fields SHALL hold their previous values on error and during reception.
REQ-021 busy SHALL be high in RECV and WAIT_EOL and low in IDLE.
REQ-022 Fields SHALL be decoded from packet_data with F = PACKET_SIZE-64:
- timestamp = [63:0]
- tick = [F+:16]
- flags = [F+16+:4]
- lag_cross = [F+20+:8]
- lag_auto = [F+28+:8]
- delay_size = [F+36+:12]
- num_inputs = [F+48+:8]
- resolution = [F+56+:8]
REQ-023 Cycles with RXIF low SHALL NOT change state; there SHALL be no timeout.
REQ-024 The nibble counter SHALL be sized clog2(PACKET_SIZE/4)+1 bits and SHALL never wrap.

Reset
REQ-025 Reset SHALL force IDLE and zero the counter, shift register, packet_data and all fields, and drive packet_valid, packet_error and busy to 0.
REQ-026 Reset asserted mid-packet SHALL discard the partial packet without a packet_error pulse.

Structure
REQ-027 A shared package SHALL hold the state encoding, HEADER_SIZE=64, FOOTER_SIZE=64 and the header field offsets/widths, which are also used by the transmit-side packet generator.
REQ-028 One sub-module hex_nibble_decode (char in -> nibble, is_hex) SHALL be instantiated; it is purely combinational.

Verification
REQ-029 PACKET_SIZE=256: 64 chars "0123456789ABCDEF" repeated, then 0x0D -> packet_valid 1 clk after CR; packet_data = 256'h0123...CDEF; timestamp = 64'h0123456789ABCDEF.
REQ-030 Lowercase "abcdef..." with correct length -> packet_data equals the uppercase-encoded equivalent, with no error.
REQ-031 'G' as the 10th character -> packet_error pulse, busy low next cycle, packet_data unchanged.
REQ-032 65th hex character before CR -> packet_error; a following valid packet is received correctly.
REQ-033 Reset after 30 characters -> IDLE, no error pulse, all outputs 0; the next full packet is accepted.
REQ-034 Header with resolution=18, num_inputs=7, delay_size=4, lag_auto=0, lag_cross=0, flags=3, tick=16'd5 -> each decoded field matches.

Source files
------------

// File: rtl/packet_receiver_pkg.sv
// -----------------------------------------------------------------------------
// packet_receiver_pkg
// Shared definitions for the hex-ASCII packet link (receive and transmit sides).
//   - FSM state encoding for the receiver
//   - Header/footer sizes
//   - Header field offsets/widths, relative to the first header bit
//     (header occupies the top HEADER_SIZE bits of a packet)
// -----------------------------------------------------------------------------
package packet_receiver_pkg;

    // Receiver FSM encoding
    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_RECV     = 2'd1;
    localparam logic [1:0] ST_WAIT_EOL = 2'd2;

    // Packet framing
    localparam int unsigned HEADER_SIZE = 64;
    localparam int unsigned FOOTER_SIZE = 64;

    // Header field layout (LSB offset within the header, width)
    localparam int unsigned TICK_OFS       = 0;
    localparam int unsigned TICK_W         = 16;
    localparam int unsigned FLAGS_OFS      = 16;
    localparam int unsigned FLAGS_W        = 4;
    localparam int unsigned LAG_CROSS_OFS  = 20;
    localparam int unsigned LAG_CROSS_W    = 8;
    localparam int unsigned LAG_AUTO_OFS   = 28;
    localparam int unsigned LAG_AUTO_W     = 8;
    localparam int unsigned DELAY_SIZE_OFS = 36;
    localparam int unsigned DELAY_SIZE_W   = 12;
    localparam int unsigned NUM_INPUTS_OFS = 48;
    localparam int unsigned NUM_INPUTS_W   = 8;
    localparam int unsigned RESOLUTION_OFS = 56;
    localparam int unsigned RESOLUTION_W   = 8;

endpackage

// File: rtl/hex_nibble_decode.sv
// -----------------------------------------------------------------------------
// hex_nibble_decode
// Purely combinational ASCII hex digit decoder.
// Ports:
//   i_char   [7:0] : ASCII character
//   o_nibble [3:0] : decoded value (0 when not a hex digit)
//   o_is_hex       : 1 for '0'-'9', 'A'-'F', 'a'-'f'
// -----------------------------------------------------------------------------
module hex_nibble_decode (
    input  logic [7:0] i_char,
    output logic [3:0] o_nibble,
    output logic       o_is_hex
);

    always_comb begin
        o_nibble = '0;
        o_is_hex = 1'b0;
        if (i_char >= 8'h30 && i_char <= 8'h39) begin
            o_nibble = i_char[3:0];
            o_is_hex = 1'b1;
        end else if ((i_char >= 8'h41 && i_char <= 8'h46) ||
                     (i_char >= 8'h61 && i_char <= 8'h66)) begin
            // 'A'/'a' have low nibble 1, so add 9 to reach 10
            o_nibble = i_char[3:0] + 4'd9;
            o_is_hex = 1'b1;
        end
    end

endmodule

// File: rtl/packet_receiver.sv
// -----------------------------------------------------------------------------
// packet_receiver
// Assembles a packet from a stream of ASCII hex characters, first nibble in
// the MSB, closed by a TERMINATOR character, and decodes the header/footer.
// Ports:
//   clk, reset (async, active-high)
//   RXREG [7:0], RXIF        : received character and its one-cycle strobe
//   packet_data              : last complete packet
//   packet_valid             : one-cycle pulse when packet_data updates
//   packet_error             : one-cycle pulse on framing error/overrun
//   busy                     : high while a packet is in progress
//   timestamp .. resolution  : fields decoded from packet_data
// -----------------------------------------------------------------------------
module packet_receiver
    import packet_receiver_pkg::*;
#(
    parameter int unsigned PACKET_SIZE = 256,
    parameter logic [7:0]  TERMINATOR  = 8'h0D
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [7:0]             RXREG,
    input  logic                   RXIF,
    output logic [PACKET_SIZE-1:0] packet_data,
    output logic                   packet_valid,
    output logic                   packet_error,
    output logic                   busy,
    output logic [63:0]            timestamp,
    output logic [15:0]            tick,
    output logic [3:0]             flags,
    output logic [7:0]             lag_cross,
    output logic [7:0]             lag_auto,
    output logic [11:0]            delay_size,
    output logic [7:0]             num_inputs,
    output logic [7:0]             resolution
);

    localparam int unsigned NIBBLES = PACKET_SIZE / 4;
    localparam int unsigned CW      = $clog2(NIBBLES) + 1;
    localparam int unsigned F       = PACKET_SIZE - HEADER_SIZE;
    localparam logic [CW-1:0] LAST_NIBBLE = CW'(NIBBLES);

    logic [1:0]             r_state;
    logic [CW-1:0]          r_count;
    logic [PACKET_SIZE-1:0] r_shift;
    logic [PACKET_SIZE-1:0] r_packet_data;
    logic                   r_valid;
    logic                   r_error;

    logic [3:0]             w_nibble;
    logic                   w_is_hex;
    logic [CW-1:0]          w_count_next;

    hex_nibble_decode u_hex_nibble_decode (
        .i_char   (RXREG),
        .o_nibble (w_nibble),
        .o_is_hex (w_is_hex)
    );

    assign w_count_next = r_count + CW'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_count       <= '0;
            r_shift       <= '0;
            r_packet_data <= '0;
            r_valid       <= 1'b0;
            r_error       <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_error <= 1'b0;
            if (RXIF) begin
                case (r_state)
                    ST_IDLE: begin
                        // Non-hex characters (stray CR/LF etc.) are ignored here
                        if (w_is_hex) begin
                            r_shift <= {{(PACKET_SIZE-4){1'b0}}, w_nibble};
                            r_count <= CW'(1);
                            r_state <= ST_RECV;
                        end
                    end
                    ST_RECV: begin
                        if (w_is_hex) begin
                            r_shift <= {r_shift[PACKET_SIZE-5:0], w_nibble};
                            r_count <= w_count_next;
                            if (w_count_next == LAST_NIBBLE) begin
                                r_state <= ST_WAIT_EOL;
                            end
                        end else begin
                            r_error <= 1'b1;
                            r_shift <= '0;
                            r_count <= '0;
                            r_state <= ST_IDLE;
                        end
                    end
                    ST_WAIT_EOL: begin
                        if (RXREG == TERMINATOR) begin
                            r_packet_data <= r_shift;
                            r_valid       <= 1'b1;
                        end else begin
                            r_error <= 1'b1;
                        end
                        r_shift <= '0;
                        r_count <= '0;
                        r_state <= ST_IDLE;
                    end
                    default: begin
                        r_shift <= '0;
                        r_count <= '0;
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign packet_data  = r_packet_data;
    assign packet_valid = r_valid;
    assign packet_error = r_error;
    assign busy         = (r_state != ST_IDLE);

    assign timestamp  = r_packet_data[FOOTER_SIZE-1:0];
    assign tick       = r_packet_data[F+TICK_OFS       +: TICK_W];
    assign flags      = r_packet_data[F+FLAGS_OFS      +: FLAGS_W];
    assign lag_cross  = r_packet_data[F+LAG_CROSS_OFS  +: LAG_CROSS_W];
    assign lag_auto   = r_packet_data[F+LAG_AUTO_OFS   +: LAG_AUTO_W];
    assign delay_size = r_packet_data[F+DELAY_SIZE_OFS +: DELAY_SIZE_W];
    assign num_inputs = r_packet_data[F+NUM_INPUTS_OFS +: NUM_INPUTS_W];
    assign resolution = r_packet_data[F+RESOLUTION_OFS +: RESOLUTION_W];

endmodule

// File: tb/tb_packet_receiver.sv
// -----------------------------------------------------------------------------
// tb_packet_receiver
// Directed testbench for packet_receiver with PACKET_SIZE=256, TERMINATOR=CR.
// -----------------------------------------------------------------------------
module tb_packet_receiver;

    logic         clk = 1'b0;
    logic         reset;
    logic [7:0]   RXREG;
    logic         RXIF;
    logic [255:0] packet_data;
    logic         packet_valid;
    logic         packet_error;
    logic         busy;
    logic [63:0]  timestamp;
    logic [15:0]  tick;
    logic [3:0]   flags;
    logic [7:0]   lag_cross;
    logic [7:0]   lag_auto;
    logic [11:0]  delay_size;
    logic [7:0]   num_inputs;
    logic [7:0]   resolution;

    int n_checks  = 0;
    int n_fail    = 0;
    int err_seen  = 0;
    int e0;

    always #5 clk = ~clk;

    packet_receiver #(
        .PACKET_SIZE (256),
        .TERMINATOR  (8'h0D)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .RXREG        (RXREG),
        .RXIF         (RXIF),
        .packet_data  (packet_data),
        .packet_valid (packet_valid),
        .packet_error (packet_error),
        .busy         (busy),
        .timestamp    (timestamp),
        .tick         (tick),
        .flags        (flags),
        .lag_cross    (lag_cross),
        .lag_auto     (lag_auto),
        .delay_size   (delay_size),
        .num_inputs   (num_inputs),
        .resolution   (resolution)
    );

    // Count error pulses (pre-edge values at each rising edge)
    always @(posedge clk) begin
        if (packet_error === 1'b1) err_seen++;
    end

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] hex_char(input logic [3:0] n, input bit lower);
        if (n < 4'd10) return 8'h30 + {4'h0, n};
        return (lower ? 8'h61 : 8'h41) + {4'h0, n} - 8'd10;
    endfunction

    // One strobed character, then one idle cycle; returns on the falling edge
    // right after the edge that sampled it.
    task automatic send_char(input logic [7:0] c);
        @(negedge clk);
        RXREG = c;
        RXIF  = 1'b1;
        @(negedge clk);
        RXIF  = 1'b0;
        RXREG = 8'h00;
    endtask

    task automatic send_hex(input logic [255:0] p, input int first, input int count, input bit lower);
        logic [3:0] nib;
        for (int i = first; i < first + count; i++) begin
            nib = p[255-4*i -: 4];
            send_char(hex_char(nib, lower));
        end
    endtask

    logic [255:0] P1, P2, P3, P4, P5;
    logic [63:0]  hdr;

    initial begin
        P1  = {4{64'h0123456789ABCDEF}};
        P2  = {4{64'hFEDCBA9876543210}};
        P3  = {64'h1122334455667788, 64'h99AABBCCDDEEFF00,
               64'h0F1E2D3C4B5A6978, 64'h8796A5B4C3D2E1F0};
        P4  = {64'hA1B2C3D4E5F60718, 64'h293A4B5C6D7E8F90,
               64'h5555AAAA5555AAAA, 64'h0000FFFF1234ABCD};
        hdr = {8'd18, 8'd7, 12'd4, 8'd0, 8'd0, 4'd3, 16'd5};
        P5  = {hdr, 128'hA5A5A5A5A5A5A5A5_5A5A5A5A5A5A5A5A, 64'hCAFEF00D12345678};

        reset = 1'b1;
        RXIF  = 1'b0;
        RXREG = 8'h00;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_valid", {255'b0, packet_valid}, 256'd0);
        check("rst_error", {255'b0, packet_error}, 256'd0);
        check("rst_busy",  {255'b0, busy},         256'd0);
        check("rst_data",  packet_data,            256'd0);
        check("rst_ts",    {192'b0, timestamp},    256'd0);
        check("rst_res",   {248'b0, resolution},   256'd0);
        reset = 1'b0;
        @(negedge clk);

        // Uppercase packet, CR latency
        send_hex(P1, 0, 1, 1'b0);
        check("p1_busy_first", {255'b0, busy}, 256'd1);
        send_hex(P1, 1, 63, 1'b0);
        check("p1_busy_full",  {255'b0, busy},         256'd1);
        check("p1_novalid",    {255'b0, packet_valid}, 256'd0);
        check("p1_data_held",  packet_data,            256'd0);
        send_char(8'h0D);
        check("p1_valid",   {255'b0, packet_valid}, 256'd1);
        check("p1_data",    packet_data,            P1);
        check("p1_ts",      {192'b0, timestamp},    {192'b0, 64'h0123456789ABCDEF});
        check("p1_res",     {248'b0, resolution},   256'h01);
        check("p1_nin",     {248'b0, num_inputs},   256'h23);
        check("p1_dly",     {244'b0, delay_size},   256'h456);
        check("p1_lauto",   {248'b0, lag_auto},     256'h78);
        check("p1_lcross",  {248'b0, lag_cross},    256'h9A);
        check("p1_flags",   {252'b0, flags},        256'hB);
        check("p1_tick",    {240'b0, tick},         256'hCDEF);
        check("p1_busy_end", {255'b0, busy},        256'd0);
        @(negedge clk);
        check("p1_valid_pulse", {255'b0, packet_valid}, 256'd0);

        // Lowercase packet
        e0 = err_seen;
        send_hex(P2, 0, 64, 1'b1);
        send_char(8'h0D);
        check("lc_valid", {255'b0, packet_valid}, 256'd1);
        check("lc_data",  packet_data,            P2);
        @(negedge clk);
        check("lc_noerr", 256'(err_seen), 256'(e0));

        // 'G' as 10th character
        send_hex(P1, 0, 9, 1'b0);
        send_char(8'h47);
        check("g_error", {255'b0, packet_error}, 256'd1);
        check("g_busy",  {255'b0, busy},         256'd0);
        check("g_data",  packet_data,            P2);
        @(negedge clk);
        check("g_error_pulse", {255'b0, packet_error}, 256'd0);

        // Overrun: 65th hex character
        send_hex(P1, 0, 64, 1'b0);
        send_char(8'h35);
        check("ov_error", {255'b0, packet_error}, 256'd1);
        check("ov_busy",  {255'b0, busy},         256'd0);
        check("ov_data",  packet_data,            P2);
        send_hex(P3, 0, 64, 1'b0);
        send_char(8'h0D);
        check("ov_next_valid", {255'b0, packet_valid}, 256'd1);
        check("ov_next_data",  packet_data,            P3);

        // Non-hex characters in IDLE are ignored
        e0 = err_seen;
        send_char(8'h0D);
        send_char(8'h0A);
        send_char(8'h5A);
        check("idle_busy", {255'b0, busy}, 256'd0);
        @(negedge clk);
        check("idle_noerr", 256'(err_seen), 256'(e0));
        check("idle_data",  packet_data,    P3);

        // Reset mid-packet
        e0 = err_seen;
        send_hex(P4, 0, 30, 1'b0);
        check("mr_busy_before", {255'b0, busy}, 256'd1);
        reset = 1'b1;
        @(negedge clk);
        check("mr_error", {255'b0, packet_error}, 256'd0);
        check("mr_valid", {255'b0, packet_valid}, 256'd0);
        check("mr_busy",  {255'b0, busy},         256'd0);
        check("mr_data",  packet_data,            256'd0);
        check("mr_tick",  {240'b0, tick},         256'd0);
        reset = 1'b0;
        @(negedge clk);
        check("mr_noerr", 256'(err_seen), 256'(e0));
        send_hex(P4, 0, 64, 1'b0);
        send_char(8'h0D);
        check("mr_next_valid", {255'b0, packet_valid}, 256'd1);
        check("mr_next_data",  packet_data,            P4);

        // Header field decode
        send_hex(P5, 0, 64, 1'b0);
        send_char(8'h0D);
        check("hd_valid",  {255'b0, packet_valid}, 256'd1);
        check("hd_res",    {248'b0, resolution},   256'd18);
        check("hd_nin",    {248'b0, num_inputs},   256'd7);
        check("hd_dly",    {244'b0, delay_size},   256'd4);
        check("hd_lauto",  {248'b0, lag_auto},     256'd0);
        check("hd_lcross", {248'b0, lag_cross},    256'd0);
        check("hd_flags",  {252'b0, flags},        256'd3);
        check("hd_tick",   {240'b0, tick},         256'd5);
        check("hd_ts",     {192'b0, timestamp},    {192'b0, 64'hCAFEF00D12345678});

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
